baud_rate_gen: RTL
==================

// Module: baud_rate_gen
// PURPOSE
//  Runtime-programmable UART baud tick generator: emits a one-cycle oversample tick (b_tick)
//  every DIV+1 clocks and a bit tick (bit_tick) every OVERSAMPLE b_ticks. Drives the UART
//  RX/TX and FIFO path; the divisor is reloadable at runtime without glitching the current period.
// PARAMETERS
//  CLK_FREQ      100_000_000  system clock frequency, Hz
//  DEFAULT_BAUD  9600         baud rate selected out of reset
//  OVERSAMPLE    16           b_ticks per bit_tick; integer >= 2
//  DIV_W         16           divisor / counter width
//  DEF_DIV       CLK_FREQ/(DEFAULT_BAUD*OVERSAMPLE)-1  reset divisor (650 by default); must fit DIV_W
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      generator enable; 0 = counters held at 0, ticks low
//  div_load  in   1      one-cycle strobe: capture div_in
//  div_in    in   DIV_W  new divisor (period = div_in+1 clocks)
//  frac_in   in   4      fractional divisor, sixteenths (only with BAUD_FRAC_EN)
//  b_tick    out  1      oversample tick, one cycle high per period
//  bit_tick  out  1      bit tick, high in the same cycle as every OVERSAMPLE-th b_tick
//  div_pend  out  1      loaded divisor waiting for the period boundary
// BEHAVIOUR
//  Reset: b_tick=0, bit_tick=0, div_pend=0, cnt=0, os_cnt=0, div_q=DEF_DIV, frac_acc=0.
//  All outputs registered; no combinational path from inputs to outputs.
//  Counting (en=1): cnt increments each clock; at the edge where cnt==div_q ("wrap"):
//   cnt<=0, b_tick<=1; else b_tick<=0. First b_tick after en rises: div_q+1 edges later.
//  os_cnt counts b_ticks 0..OVERSAMPLE-1; on a wrap with os_cnt==OVERSAMPLE-1: os_cnt<=0,
//   bit_tick<=1 (coincident with b_tick); bit_tick is 0 in all other cycles.
//  div_q==0: b_tick high every cycle while en=1; bit_tick every OVERSAMPLE cycles.
//  Divisor load: div_load captures div_in into div_nxt, div_pend<=1. div_q<=div_nxt only at
//   a wrap edge (current period always completes with the old divisor); div_pend then clears.
//   div_load on the wrap edge itself: div_in goes directly to div_q, div_pend stays 0.
//   Repeated loads before the boundary: last value wins.
//   en=0: a pending divisor is applied on the next clock edge and div_pend clears.
//  en deassert: on the next edge cnt, os_cnt, frac_acc <=0 and b_tick, bit_tick <=0;
//   re-enable restarts a full period and a full OVERSAMPLE group (no partial bit).
//  Counter arithmetic: cnt is DIV_W bits; compare is exact equality, so wrap never overflows.
//  Asynchronous reset mid-period: immediate return to reset values, including div_q=DEF_DIV;
//   any pending load is discarded.
// CONFIGURATION
//  BAUD_FRAC_EN defined: frac_in port present; 4-bit frac_acc += frac_in at each wrap; on
//   carry-out the next period is div_q+2 clocks (one stretch cycle), otherwise div_q+1.
//   Average period = div_q+1+frac_in/16. frac_in is sampled at the wrap edge.
//  BAUD_FRAC_EN undefined: no frac_in port, no accumulator; period is exactly div_q+1.
// TESTING
//  1 rst pulse, en=1, no loads -> first b_tick at cycle 651, then every 651 clocks;
//    bit_tick every 10416 clocks, aligned with b_tick.
//  2 div_load div_in=3 at cycle 100 -> div_pend=1 until cycle 651 wrap; subsequent b_ticks
//    every 4 clocks; bit_tick every 64 clocks.
//  3 div_in=0 loaded, en=1 -> b_tick constant 1; bit_tick high 1 in 16 cycles.
//  4 en low for 5 cycles mid-period (cnt=200, os_cnt=7) -> ticks 0, counters 0;
//    after en=1, b_tick in div_q+1 cycles, bit_tick after 16 b_ticks.
//  5 rst asserted mid-period with load pending -> outputs 0 same cycle, div_pend=0,
//    post-reset period 651 (pending divisor dropped).
//  6 (BAUD_FRAC_EN) div_q=3, frac_in=8 -> b_tick periods alternate 4,5,4,5;
//    frac_in=0 -> constant 4.

Source files
------------

// File: rtl/baud_rate_gen.sv
// -----------------------------------------------------------------------------
// baud_rate_gen
//   Runtime-programmable UART baud tick generator. Emits a one-cycle
//   oversample tick (b_tick) every div_q+1 clocks and a bit tick (bit_tick)
//   coincident with every OVERSAMPLE-th b_tick. A newly loaded divisor waits
//   for the current period to finish so the running period never glitches.
//
//   Optional feature macro: BAUD_FRAC_EN
//     Adds the frac_in port and a 4-bit fractional accumulator. A carry out of
//     the accumulator stretches the following period by one clock, giving an
//     average period of div_q+1+frac_in/16.
// -----------------------------------------------------------------------------
module baud_rate_gen #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = 16,
  parameter int DEF_DIV      = CLK_FREQ / (DEFAULT_BAUD * OVERSAMPLE) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]       frac_in,
`endif
  output logic             b_tick,
  output logic             bit_tick,
  output logic             div_pend
);

  localparam int               OS_W      = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [OS_W-1:0]  os_cnt_q,   os_cnt_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [DIV_W-1:0] div_nxt_q,  div_nxt_d;
  logic             div_pend_q, div_pend_d;
  logic             b_tick_q,   b_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             at_limit;
  logic             wrap;

`ifdef BAUD_FRAC_EN
  logic [3:0]       frac_acc_q, frac_acc_d;
  logic             stretch_q,  stretch_d;

  // A pending stretch holds the counter at its limit for one extra clock, so
  // the compare stays exact equality and the counter can never overflow.
  assign at_limit = (cnt_q == div_q);
  assign wrap     = at_limit && !stretch_q;
`else
  assign at_limit = (cnt_q == div_q);
  assign wrap     = at_limit;
`endif

  // Next-state logic for counters, divisor staging and tick generation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    div_d      = div_q;
    div_nxt_d  = div_nxt_q;
    div_pend_d = div_pend_q;
    b_tick_d   = 1'b0;
    bit_tick_d = 1'b0;
`ifdef BAUD_FRAC_EN
    frac_acc_d = frac_acc_q;
    stretch_d  = stretch_q;
`endif

    if (!en) begin
      // Disabled: hold everything at the start of a period and bit group,
      // and take any staged divisor immediately since no period is running.
      cnt_d    = '0;
      os_cnt_d = '0;
`ifdef BAUD_FRAC_EN
      frac_acc_d = '0;
      stretch_d  = 1'b0;
`endif
      if (div_pend_q) begin
        div_d      = div_nxt_q;
        div_pend_d = 1'b0;
      end
      if (div_load) begin
        div_nxt_d  = div_in;
        div_pend_d = 1'b1;
      end
    end else if (wrap) begin
      // Period boundary: emit the oversample tick and advance the bit group.
      cnt_d    = '0;
      b_tick_d = 1'b1;
      if (os_cnt_q == OS_LAST) begin
        os_cnt_d   = '0;
        bit_tick_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt_q + 1'b1;
      end

      // The boundary is the only place the running divisor may change; a
      // load arriving on this very edge bypasses the staging register.
      if (div_load) begin
        div_d = div_in;
      end else if (div_pend_q) begin
        div_d = div_nxt_q;
      end
      div_pend_d = 1'b0;

`ifdef BAUD_FRAC_EN
      {stretch_d, frac_acc_d} = {1'b0, frac_acc_q} + {1'b0, frac_in};
`endif
    end else begin
      // Mid-period: keep counting and stage any new divisor (last one wins).
`ifdef BAUD_FRAC_EN
      if (at_limit) begin
        stretch_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`else
      cnt_d = cnt_q + 1'b1;
`endif
      if (div_load) begin
        div_nxt_d  = div_in;
        div_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset returns to the default divisor and drops any
  // staged load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      div_q      <= DEF_DIV_V;
      div_nxt_q  <= DEF_DIV_V;
      div_pend_q <= 1'b0;
      b_tick_q   <= 1'b0;
      bit_tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_acc_q <= '0;
      stretch_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge values computed above, independent of statement order.
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      div_q      <= div_d;
      div_nxt_q  <= div_nxt_d;
      div_pend_q <= div_pend_d;
      b_tick_q   <= b_tick_d;
      bit_tick_q <= bit_tick_d;
`ifdef BAUD_FRAC_EN
      frac_acc_q <= frac_acc_d;
      stretch_q  <= stretch_d;
`endif
    end
  end

  assign b_tick   = b_tick_q;
  assign bit_tick = bit_tick_q;
  assign div_pend = div_pend_q;

  // Structural invariants: a bit tick always rides on a b_tick, and the
  // period counter never runs past the active divisor.
  a_bit_on_b_tick : assert property (@(posedge clk) disable iff (rst)
    bit_tick_q |-> b_tick_q);
  a_cnt_in_range : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= div_q);

endmodule
